// File: rtl/queue_arbiter.sv
// Four-requester round-robin arbiter feeding a first-word fall-through FIFO.
// Define QUEUE_ARBITER_TAG_EN to store and present the winning requester index (Qsrc).
module queue_arbiter #(
    parameter int unsigned Width        = 8,
    parameter int unsigned AddressWidth = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req,
    input  logic [4*Width-1:0]      D,
    output logic [3:0]              grant,
    input  logic                    pull,
    output logic [Width-1:0]        Q,
`ifdef QUEUE_ARBITER_TAG_EN
    output logic [1:0]              Qsrc,
`endif
    output logic                    void_o,
    output logic                    full,
    output logic [AddressWidth:0]   count
);

    localparam int unsigned Depth = 2 ** AddressWidth;
`ifdef QUEUE_ARBITER_TAG_EN
    localparam int unsigned EntryWidth = Width + 2;
`else
    localparam int unsigned EntryWidth = Width;
`endif

    logic [1:0]              ptr_q, ptr_d;
    logic [AddressWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddressWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddressWidth:0]   count_q, count_d;
    logic [EntryWidth-1:0]   mem_q [Depth];

    logic                    push, pop, found;
    logic [1:0]              win, idx;
    logic [EntryWidth-1:0]   wdata;

    assign void_o = (count_q == '0);
    assign full   = (count_q == (AddressWidth + 1)'(Depth));
    assign count  = count_q;
    assign pop    = pull & ~void_o;

    // A pop in the same cycle frees the slot, so a full queue may still accept.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        if (!rst && (!full || pop)) begin
            for (int k = 0; k < 4; k++) begin
                idx = ptr_q + 2'(k);
                if (!found && req[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        push  = found;
        grant = found ? (4'b0001 << win) : 4'b0000;
    end

    always_comb begin
`ifdef QUEUE_ARBITER_TAG_EN
        wdata = {win, D[Width*win +: Width]};
`else
        wdata = D[Width*win +: Width];
`endif
    end

    always_comb begin
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ptr_d    = win + 2'd1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign Q = mem_q[rd_ptr_q][Width-1:0];
`ifdef QUEUE_ARBITER_TAG_EN
    assign Qsrc = mem_q[rd_ptr_q][Width+1:Width];
`endif

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_queue_arbiter;

    localparam int Width = 8;
    localparam int Depth = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [3:0]           req = '0;
    logic [4*Width-1:0]   d = '0;
    logic [3:0]           grant;
    logic                 pull = 1'b0;
    logic [Width-1:0]     q;
    logic                 void_o;
    logic                 full;
    logic [2:0]           count;
`ifdef QUEUE_ARBITER_TAG_EN
    logic [1:0]           qsrc;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: queue of words and source indices plus round-robin pointer.
    logic [Width-1:0] m_data[$];
    int               m_src[$];
    int               m_ptr = 0;

    queue_arbiter #(.Width(Width), .AddressWidth(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .D      (d),
        .grant  (grant),
        .pull   (pull),
        .Q      (q),
`ifdef QUEUE_ARBITER_TAG_EN
        .Qsrc   (qsrc),
`endif
        .void_o (void_o),
        .full   (full),
        .count  (count)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_grant(input logic [3:0] r, input logic p);
        bit pop_ok;
        int i;
        pop_ok = p && (m_data.size() > 0);
        if (m_data.size() == Depth && !pop_ok) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (r[i]) return 4'(1 << i);
        end
        return 4'b0000;
    endfunction

    // Advance one clock edge and update the model; returns at posedge + 1.
    task automatic tick();
        logic [3:0] g;
        int w;
        g = model_grant(req, pull);
        @(posedge clk);
        if (pull && m_data.size() > 0) begin
            void'(m_data.pop_front());
            void'(m_src.pop_front());
        end
        if (g != 0) begin
            w = $clog2(int'(g));
            m_data.push_back(d[Width*w +: Width]);
            m_src.push_back(w);
            m_ptr = (w + 1) % 4;
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_data.delete();
        m_src.delete();
        m_ptr = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        req = 4'b1111;
        pull = 1'b1;
        rst = 1'b1;
        #2;
        checks++;
        if (void_o !== 1'b1 || full !== 1'b0 || count !== 3'd0 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset: void=%b full=%b count=%0d grant=%b, want 1 0 0 0000",
                     void_o, full, count, grant);
        end
        req = '0;
        pull = 1'b0;
        do_reset();
    endtask

    task automatic test_fill();
        req = 4'b1111;
        pull = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom()};
            #2;
            checks++;
            if (grant !== 4'(1 << i)) begin
                errors++;
                $display("FAIL fill_grant%0d: got %b want %b", i, grant, 4'(1 << i));
            end
            tick();
        end
        #2;
        checks++;
        if (full !== 1'b1 || grant !== 4'b0000 || count !== 3'd4 || q !== m_data[0]) begin
            errors++;
            $display("FAIL fill_full: full=%b grant=%b count=%0d q=%h, want 1 0000 4 %h",
                     full, grant, count, q, m_data[0]);
        end
    endtask

    task automatic test_full_pushpop();
        logic [Width-1:0] second;
        second = m_data[1];
        req = 4'b0001;
        pull = 1'b1;
        d = {$urandom(), $urandom()};
        #2;
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL full_pushpop_grant: got %b want 0001", grant);
        end
        tick();
        req = '0;
        pull = 1'b0;
        #2;
        checks++;
        if (count !== 3'd4 || q !== second) begin
            errors++;
            $display("FAIL full_pushpop_state: count=%0d q=%h, want 4 %h", count, q, second);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req = 4'b1010;
        pull = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = {$urandom(), $urandom()};
            #2;
            checks++;
            if (grant !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                errors++;
                $display("FAIL alternate%0d: got %b want %b", i, grant,
                         (i % 2 == 0) ? 4'b0010 : 4'b1000);
            end
            tick();
        end
        req = '0;
        pull = 1'b0;
    endtask

    task automatic test_empty_pull();
        do_reset();
        pull = 1'b1;
        tick();
        pull = 1'b0;
        #2;
        checks++;
        if (void_o !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL empty_pull: void=%b count=%0d, want 1 0", void_o, count);
        end
        req = 4'b0100;
        d = '0;
        d[16 +: 8] = 8'hA5;
        #2;
        checks++;
        if (grant !== 4'b0100 || void_o !== 1'b1) begin
            errors++;
            $display("FAIL empty_push_grant: grant=%b void=%b, want 0100 1", grant, void_o);
        end
        tick();
        req = '0;
        #2;
        checks++;
        if (void_o !== 1'b0 || q !== 8'hA5) begin
            errors++;
            $display("FAIL empty_push_head: void=%b q=%h, want 0 a5", void_o, q);
        end
`ifdef QUEUE_ARBITER_TAG_EN
        checks++;
        if (qsrc !== 2'd2) begin
            errors++;
            $display("FAIL empty_push_src: got %0d want 2", qsrc);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            d = {$urandom(), $urandom()};
            tick();
        end
        req = '0;
        #1;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL reset_mid_pre: count=%0d want 3", count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (void_o !== 1'b1 || full !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_async: void=%b full=%b count=%0d, want 1 0 0",
                     void_o, full, count);
        end
        do_reset();
        req = 4'b1000;
        #2;
        checks++;
        if (grant !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_grant: got %b want 1000", grant);
        end
        tick();
        req = '0;
    endtask

    task automatic test_count1();
        logic [Width-1:0] nw;
        do_reset();
        req = 4'b0001;
        d = {$urandom(), $urandom()};
        tick();
        nw = 8'($urandom());
        req = 4'b0010;
        d[8 +: 8] = nw;
        pull = 1'b1;
        #2;
        checks++;
        if (grant !== 4'b0010) begin
            errors++;
            $display("FAIL count1_grant: got %b want 0010", grant);
        end
        tick();
        req = '0;
        pull = 1'b0;
        #2;
        checks++;
        if (count !== 3'd1 || q !== nw) begin
            errors++;
            $display("FAIL count1_head: count=%0d q=%h, want 1 %h", count, q, nw);
        end
    endtask

    task automatic test_random();
        logic [3:0] eg;
        int thr;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            thr  = ((i / 50) % 2 == 0) ? 25 : 75;
            req  = 4'($urandom());
            d    = {$urandom(), $urandom()};
            pull = ($urandom_range(0, 99) < thr);
            #2;
            eg = model_grant(req, pull);
            checks++;
            if (grant !== eg || count !== 3'(m_data.size()) ||
                void_o !== (m_data.size() == 0) || full !== (m_data.size() == Depth)) begin
                errors++;
                $display("FAIL random%0d: grant=%b count=%0d void=%b full=%b, want %b %0d",
                         i, grant, count, void_o, full, eg, m_data.size());
            end
            if (m_data.size() > 0) begin
                checks++;
                if (q !== m_data[0]) begin
                    errors++;
                    $display("FAIL random_q%0d: got %h want %h", i, q, m_data[0]);
                end
`ifdef QUEUE_ARBITER_TAG_EN
                checks++;
                if (qsrc !== 2'(m_src[0])) begin
                    errors++;
                    $display("FAIL random_src%0d: got %0d want %0d", i, qsrc, m_src[0]);
                end
`endif
            end
            tick();
        end
        req = '0;
        pull = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_full_pushpop();
        test_alternate();
        test_empty_pull();
        test_reset_mid();
        test_count1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameter: Width, 8, data word width in bits.
REQ-002 Parameter: AddressWidth, 2, FIFO address width; depth = 2**AddressWidth words.
REQ-003 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req  input  4  push request; bit i is requester i.
REQ-006 Port: D  input  4*Width  requester data; requester i at D[Width*i +: Width].
REQ-007 Port: grant  output  4  one-hot accept strobe; grant[i]=1 means requester i's word is written at this edge.
REQ-008 Port: pull  input  1  consumer pop request.
REQ-009 Port: Q  output  Width  head-of-queue word, first-word fall-through.
REQ-010 Port: Qsrc  output  2  requester index of head word (present only with QUEUE_ARBITER_TAG_EN).
REQ-011 Port: void  output  1  FIFO empty.
REQ-012 Port: full  output  1  FIFO holds depth words.
REQ-013 Port: count  output  AddressWidth+1  current occupancy.

Function
REQ-014 Arbitration: round-robin over 4 requesters; search starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ... mod 4; the first asserted req wins.
REQ-015 grant: combinational from req, ptr, full, pull and void; at most one bit high per cycle.
REQ-016 On any grant to i: word D[i] is written at the tail, and ptr <= (i+1) mod 4 at the same edge; no grant leaves ptr unchanged.
REQ-017 Full: no grant while full=1, except when pull=1 in the same cycle (simultaneous push/pop on full permitted; count stays at depth).
REQ-018 Pull: accepted only when void=0; head advances at the edge; pull while void=1 is ignored with no state change.
REQ-019 Simultaneous accepted push and pull: count unchanged; the written word and the popped word are distinct, including when count=1.
REQ-020 Push into empty: Q and void update one cycle after the grant edge (void=0, Q=written word); no same-cycle bypass.
REQ-021 Pointers: read/write addresses wrap modulo depth; full = (count==depth); void = (count==0).
REQ-022 Q is don't-care while void=1.
REQ-023 A requester holds req and D until its grant; a deasserted req is never granted.

Reset
REQ-024 rst=1 asynchronously forces: ptr=0, count=0, read/write pointers=0, void=1, full=0, grant=0 (masked combinationally during reset).
REQ-025 Reset mid-operation discards all queued words; the first cycle after release behaves as the post-reset state, with requester 0 highest priority.
REQ-026 Storage array is not reset.

Configuration
REQ-027 Macro QUEUE_ARBITER_TAG_EN defined: each FIFO entry stores Width+2 bits (data plus 2-bit winning requester index); Qsrc presents the head entry's index with the same timing as Q.
REQ-028 Macro QUEUE_ARBITER_TAG_EN undefined: Qsrc port absent; entries store Width bits only; all other behaviour identical.

Verification
REQ-029 After reset, req=4'b1111, pull=0 -> grants 0001, 0010, 0100, 1000 on consecutive cycles; then full=1, grant=0, count=4 (AddressWidth=2).
REQ-030 Full FIFO, req=4'b0001, pull=1 for one cycle -> grant=0001 in that cycle; count stays 4; Q advances to second-oldest word.
REQ-031 req=4'b1010 held, ptr=0, with continuous pulls -> grant alternates 0010, 1000, 0010, ...; requester 0 and 2 never granted.
REQ-032 Empty FIFO, pull=1 -> no state change; void=1, count=0; then push 8'hA5 from requester 2 -> next cycle void=0, Q=8'hA5, Qsrc=2 (TAG_EN).
REQ-033 count=3, rst pulsed mid-cycle -> void=1, full=0, count=0 immediately; next req=4'b1000 -> grant=1000 (ptr 0 search reaches 3).
REQ-034 count=1, push and pull in the same cycle -> count=1; Q shows the new word next cycle.
